pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Output-side counterpart of the input debouncer. The debouncer turns slow, bouncy human inputs into clean signals; this block turns single-cycle CPU/IO events into human-visible LED pulses of guaranteed minimum width and minimum off-gap.
- Sits between IO-mapped event strobes and board LEDs or other slow outputs.
- Uses a shared tick prescaler and an independent FSM per channel.

Parameters:
- WIDTH, 1, number of independent channels.
- TICK_CNT_MAX, 25000, clock cycles per tick; must be >= 2.
- HOLD_TICKS, 150, ticks the output stays high; must be >= 1.
- GAP_TICKS, 50, ticks the output is forced low after a hold; 0 disables the gap.
- RETRIGGER, 1, 1 = an event during HOLD restarts the hold; 0 = the event is ignored.
- TICK_CNT_WIDTH, $clog2(TICK_CNT_MAX)+1, width of the prescaler counter.
- HOLD_CNT_WIDTH, $clog2(HOLD_TICKS+GAP_TICKS)+1, width of the per-channel counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- event_pulse, input, WIDTH, per-channel event strobe; any cycle it is high counts as one event.
- stretched_signal, output, WIDTH, registered, high while the channel is in HOLD.
- busy, output, WIDTH, registered, high while the channel is not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler=0; all channels IDLE with cnt=0 and pending=0; stretched_signal=0; busy=0.
- Prescaler: increments every cycle and wraps from TICK_CNT_MAX-1 to 0.
  - tick = (prescaler == TICK_CNT_MAX-1), combinational, shared by all channels.
  - First tick occurs in cycle TICK_CNT_MAX-1 after reset release (cycle 0 = first edge with rst_n high).
- Channel FSM states: IDLE, HOLD, GAP. Outputs are decoded from next state and registered, so latency from event to output is 1 cycle.
- IDLE:
  - event → HOLD, cnt=0.
  - otherwise stay.
- HOLD (stretched=1):
  - On tick: if cnt==HOLD_TICKS-1 → GAP with cnt=0 (or IDLE if GAP_TICKS==0); else cnt++.
  - RETRIGGER=1 and event → stay HOLD, cnt=0. This takes priority over a simultaneous expiry tick.
  - RETRIGGER=0 and event → no effect.
  - Resulting high time: (HOLD_TICKS-1)*TICK_CNT_MAX+1 to HOLD_TICKS*TICK_CNT_MAX cycles, depending on prescaler phase.
- GAP (stretched=0, busy=1):
  - Event → pending=1. Single-deep: multiple events collapse into one.
  - On tick with cnt==GAP_TICKS-1: if pending or event this cycle → HOLD, cnt=0, pending=0; else → IDLE.
  - Other ticks: cnt++.
- Channels are fully independent. Simultaneous events on several channels are all accepted.
- Counters never overflow; cnt is bounded by the tick-expiry compares.
- Reset mid-operation: immediate return to reset values. Pending events are discarded.

Decomposition:
- Shared header (included Verilog file) holds localparams for state encoding: ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module, stretch_channel: FSM, cnt, pending, and output registers. Inputs are clk, rst_n, tick, event. Instantiated WIDTH times in a generate loop.
- The top level holds only the prescaler and tick decode.

Test Plan:
All scenarios use WIDTH=2, TICK_CNT_MAX=4, HOLD_TICKS=3, GAP_TICKS=2, RETRIGGER=1; ticks fall at cycles 3, 7, 11, 15, 19.
1. Single event: event_pulse[0] high in cycle 0 → stretched_signal[0] high cycles 1–11, low from cycle 12; busy[0] high cycles 1–19, low from cycle 20; channel 1 stays 0 throughout.
2. Retrigger: events in cycles 0 and 9 → HOLD restarts in cycle 10; the tick at 11 gives cnt=1 and the tick at 15 gives cnt=2; stretched_signal[0] high cycles 1–19, falls at cycle 20.
3. Event during GAP: event in cycle 0, second event in cycle 13 → pending set; after GAP expiry at the tick in cycle 19, stretched_signal[0] rises again in cycle 20 and stays high through cycle 31.
4. Channel independence with RETRIGGER=0: event on ch0 at cycle 0 and ch1 at cycle 5, plus a second ch0 event at cycle 4 → ch0 timing identical to scenario 1 (second event ignored); ch1 high cycles 6–15.
5. Reset mid-HOLD: event at cycle 0, rst_n low at cycle 5 (asynchronous, mid-cycle) → stretched_signal and busy go 0 immediately. After release, with no events, both stay 0 and the first tick occurs 3 cycles after release.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher channel FSMs.
package pulse_stretcher_pkg;

  // Channel FSM state encoding; 2'd3 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Index of the last tick in a phase of n ticks (0 when the phase is empty).
  function automatic int unsigned last_index(input int unsigned n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/pulse_stretcher_stretch_channel.sv
// One pulse-stretcher channel: HOLD/GAP sequencing, single-deep pending event.
module stretch_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 150,
  parameter int unsigned GAP_TICKS  = 50,
  parameter int unsigned RETRIGGER  = 1,
  parameter int unsigned CNT_WIDTH  = $clog2(HOLD_TICKS + GAP_TICKS) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic event_in,
  output logic stretched,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(last_index(HOLD_TICKS));
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(last_index(GAP_TICKS));
  localparam bit                   HAS_GAP   = (GAP_TICKS > 0);
  localparam bit                   RETRIG_EN = (RETRIGGER != 0);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 pending;
  logic                 pending_nxt;

  // State, counter, pending flag and outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      stretched <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      stretched <= (state_nxt == ST_HOLD);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic; a retrigger beats a simultaneous hold expiry.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    case (state)
      ST_IDLE: begin
        if (event_in) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (RETRIG_EN && event_in) begin
          cnt_nxt = '0;
        end else if (tick) begin
          if (cnt == HOLD_LAST) begin
            state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
      end
      ST_GAP: begin
        if (event_in) begin
          pending_nxt = 1'b1;
        end
        if (tick) begin
          if (cnt == GAP_LAST) begin
            state_nxt   = (pending || event_in) ? ST_HOLD : ST_IDLE;
            cnt_nxt     = '0;
            pending_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into minimum-width, minimum-gap pulses.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned TICK_CNT_MAX   = 25000,
  parameter int unsigned HOLD_TICKS     = 150,
  parameter int unsigned GAP_TICKS      = 50,
  parameter int unsigned RETRIGGER      = 1,
  parameter int unsigned TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX) + 1,
  parameter int unsigned HOLD_CNT_WIDTH = $clog2(HOLD_TICKS + GAP_TICKS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] event_pulse,
  output logic [WIDTH-1:0] stretched_signal,
  output logic [WIDTH-1:0] busy
);

  localparam logic [TICK_CNT_WIDTH-1:0] PRE_LAST = TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);

  logic [TICK_CNT_WIDTH-1:0] prescaler;
  logic                      tick;

  // Shared tick: one cycle in every TICK_CNT_MAX.
  assign tick = (prescaler == PRE_LAST);

  // Free-running prescaler wrapping at TICK_CNT_MAX-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + TICK_CNT_WIDTH'(1);
    end
  end

  // Independent channel per event bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    stretch_channel #(
      .HOLD_TICKS (HOLD_TICKS),
      .GAP_TICKS  (GAP_TICKS),
      .RETRIGGER  (RETRIGGER),
      .CNT_WIDTH  (HOLD_CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .event_in  (event_pulse[i]),
      .stretched (stretched_signal[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random events, two instances
// (retrigger on / off) driven by the same strobes and checked against a deadline model.
module tb_pulse_stretcher;

  localparam int TCM = 4;
  localparam int HT  = 3;
  localparam int GT  = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] event_pulse;
  logic [1:0] str_rt, busy_rt, str_nr, busy_nr;

  int c;
  int n_cmp;
  int n_err;

  // Model: per instance d (0 = retrigger, 1 = no retrigger) and channel.
  // mode 0 idle, 1 hold, 2 gap; dl = cycle of the tick that ends the phase.
  int md [2][2];
  int dl [2][2];
  bit pd [2][2];

  pulse_stretcher #(
    .WIDTH(2), .TICK_CNT_MAX(TCM), .HOLD_TICKS(HT), .GAP_TICKS(GT), .RETRIGGER(1)
  ) u_rt (
    .clk(clk), .rst_n(rst_n), .event_pulse(event_pulse),
    .stretched_signal(str_rt), .busy(busy_rt)
  );

  pulse_stretcher #(
    .WIDTH(2), .TICK_CNT_MAX(TCM), .HOLD_TICKS(HT), .GAP_TICKS(GT), .RETRIGGER(0)
  ) u_nr (
    .clk(clk), .rst_n(rst_n), .event_pulse(event_pulse),
    .stretched_signal(str_nr), .busy(busy_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle of the n-th tick strictly after cycle cc (ticks where cc % TCM == TCM-1).
  function automatic int nth_tick(input int cc, input int n);
    int first;
    if (cc % TCM == TCM - 1) first = cc + TCM;
    else                     first = (cc / TCM) * TCM + TCM - 1;
    return first + (n - 1) * TCM;
  endfunction

  function automatic logic [1:0] exp_str(input int d);
    logic [1:0] r;
    for (int ch = 0; ch < 2; ch++) r[ch] = (md[d][ch] == 1);
    return r;
  endfunction

  function automatic logic [1:0] exp_busy(input int d);
    logic [1:0] r;
    for (int ch = 0; ch < 2; ch++) r[ch] = (md[d][ch] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 2; ch++) begin
        md[d][ch] = 0;
        dl[d][ch] = 0;
        pd[d][ch] = 1'b0;
      end
  endtask

  task automatic model_step(input logic [1:0] ev);
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 2; ch++) begin
        case (md[d][ch])
          0: if (ev[ch]) begin
               md[d][ch] = 1;
               dl[d][ch] = nth_tick(c, HT);
             end
          1: if (d == 0 && ev[ch]) begin
               dl[d][ch] = nth_tick(c, HT);
             end else if (c == dl[d][ch]) begin
               md[d][ch] = 2;
               dl[d][ch] = nth_tick(c, GT);
             end
          default: if (c == dl[d][ch]) begin
               if (pd[d][ch] || ev[ch]) begin
                 md[d][ch] = 1;
                 dl[d][ch] = nth_tick(c, HT);
               end else begin
                 md[d][ch] = 0;
               end
               pd[d][ch] = 1'b0;
             end else if (ev[ch]) begin
               pd[d][ch] = 1'b1;
             end
        endcase
      end
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, c);
    end
  endtask

  task automatic check_outputs();
    check("str_rt",  str_rt,  exp_str(0));
    check("busy_rt", busy_rt, exp_busy(0));
    check("str_nr",  str_nr,  exp_str(1));
    check("busy_nr", busy_nr, exp_busy(1));
  endtask

  // Called between edges: drive strobes, clock once, compare just after the edge.
  task automatic step(input logic [1:0] ev);
    event_pulse = ev;
    @(posedge clk);
    model_step(ev);
    #1;
    check_outputs();
    check("tick", {1'b0, u_rt.tick}, {1'b0, ((c + 1) % TCM) == TCM - 1});
    c++;
  endtask

  // Hold reset over two edges, release mid-cycle so the next edge is cycle 0.
  task automatic do_reset();
    rst_n       = 1'b0;
    event_pulse = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("tick_rst", {1'b0, u_rt.tick}, 2'b00);
    #2;
    rst_n = 1'b1;
    c     = 0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    c           = 0;
    rst_n       = 1'b0;
    event_pulse = 2'b00;
    model_reset();

    // Single event on ch0.
    do_reset();
    for (int k = 0; k < 24; k++) step({1'b0, k == 0});

    // Retrigger during HOLD.
    do_reset();
    for (int k = 0; k < 26; k++) step({1'b0, k == 0 || k == 9});

    // Event during GAP becomes pending.
    do_reset();
    for (int k = 0; k < 36; k++) step({1'b0, k == 0 || k == 13});

    // Two channels at once, extra ch0 event in HOLD.
    do_reset();
    for (int k = 0; k < 24; k++) step({k == 5, k == 0 || k == 4});

    // Retrigger coinciding with an expiry tick, and event on the GAP expiry tick.
    do_reset();
    for (int k = 0; k < 40; k++) step({k == 19, k == 0 || k == 11});

    // Asynchronous reset in the middle of HOLD.
    do_reset();
    for (int k = 0; k < 5; k++) step({1'b0, k == 0});
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst_n = 1'b1;
    c     = 0;
    for (int k = 0; k < 12; k++) step(2'b00);
    for (int k = 0; k < 16; k++) step({1'b0, k == 0});

    // Random strobes on both channels.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 150; k++)
        step({$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
